mul_seq_ctrl: RTL and testbench
===============================

// Module: mul_seq_ctrl
// PURPOSE
//  Sequential shift-and-add multiplier controller for the RV64M MUL/MULH/MULHSU/MULHU ops.
//  Drives one shared adder instance over DATA_WIDTH iterations and performs sign
//  correction, freeing the core from a full array multiplier. Sits in the execute
//  stage beside the ALU; the hazard unit stalls on o_busy.
// PARAMETERS
//  DATA_WIDTH  64  operand/result width (XLEN); the internal adder is DATA_WIDTH+1 wide
// PORTS
//  i_clk      in   1           clock, all state on rising edge
//  i_arst     in   1           asynchronous active-high reset
//  i_start    in   1           request strobe; accepted only in IDLE
//  i_op       in   2           00 MUL, 01 MULH, 10 MULHSU, 11 MULHU (matches funct3[1:0])
//  i_rs1      in   DATA_WIDTH  multiplicand operand
//  i_rs2      in   DATA_WIDTH  multiplier operand
//  i_kill     in   1           pipeline flush; aborts an in-flight op
//  o_busy     out  1           1 in any state other than IDLE
//  o_done     out  1           one-cycle pulse when o_result is valid
//  o_result   out  DATA_WIDTH  low half (MUL) or high half (MULH*) of the 2*DATA_WIDTH product
// BEHAVIOUR
//  Reset (async, i_arst=1): state=IDLE, counter=0, product=0; o_busy=0, o_done=0, o_result=0.
//  Signedness: rs1 signed for MULH/MULHSU; rs2 signed for MULH only; MUL is treated as unsigned.
//  States:
//  - IDLE: if i_start && !i_kill, latch |rs1| -> mcand, |rs2| -> low half of product,
//    hi half=0, neg = sign(rs1)^sign(rs2) for the signed operands, op; goto MUL, count=0.
//    Abs of the most-negative value is 2^(W-1) as unsigned; no overflow.
//  - MUL: sum = {1'b0,hi} + (prod[0] ? {1'b0,mcand} : 0) through the adder;
//    {hi,lo} <= {sum,lo} >> 1 (the carry bit enters the MSB). count++; after DATA_WIDTH
//    iterations (count==DATA_WIDTH-1) goto FIX.
//  - FIX: if neg, product <= ~product + 1 (full 2W bits); goto DONE.
//  - DONE: o_done=1 for this cycle only; o_result set from lo or hi per op; goto IDLE.
//  Latency: start accepted at edge N; o_done high in cycle N+DATA_WIDTH+2 (66 for W=64).
//  o_result holds its value until the next DONE; it is not cleared on IDLE/kill.
//  i_start while o_busy=1: ignored, with no queuing. Back-to-back: a start in the cycle
//  after DONE is accepted.
//  i_kill: in any state, next state=IDLE, no o_done; kill has priority over start and done.
//  Reset mid-operation: immediate IDLE, all outputs zero, no o_done.
//  Operand registers are the only source during MUL; i_rs1/i_rs2 changes are ignored.
// STRUCTURE
//  Package mul_pkg: mul_op_t enum (MUL/MULH/MULHSU/MULHU), mul_state_t enum
//  (IDLE/MUL/FIX/DONE), localparam CNT_W = $clog2(DATA_WIDTH).
//  Sub-module: adder #(.DATA_WIDTH(DATA_WIDTH+1)) for the iteration add. The FIX negation
//  is local combinational logic. FSM, counter and product register live in this module.
// TESTING (W=64)
//  MUL 3*5 -> o_done exactly 66 cycles after start, o_result=15, single pulse.
//  MULH -1*-1 -> 0; MUL -1*-1 -> 1.
//  MULHU 0xFFFF_FFFF_FFFF_FFFF^2 -> 0xFFFF_FFFF_FFFF_FFFE.
//  MULHSU rs1=-1, rs2=0xFFFF_FFFF_FFFF_FFFF -> 0xFFFF_FFFF_FFFF_FFFF.
//  MULH 0x8000_0000_0000_0000^2 -> 0x4000_0000_0000_0000.
//  Start again at cycle 10 (ignored); i_kill at cycle 30 -> IDLE, no done; i_arst at
//  cycle 20 -> outputs 0.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared types for the sequential multiplier controller.
// Op encoding follows funct3[1:0] of the RV64M multiply group.
package mul_pkg;

  localparam int XLEN = 64;

  function automatic int cnt_w(input int w);
    return $clog2(w);
  endfunction

  localparam int CNT_W = cnt_w(XLEN);

  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_MULH   = 2'b01,
    OP_MULHSU = 2'b10,
    OP_MULHU  = 2'b11
  } mul_op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_MUL  = 2'b01,
    S_FIX  = 2'b10,
    S_DONE = 2'b11
  } mul_state_t;

endpackage

// File: rtl/adder.sv
// Plain ripple/inferred adder shared by every shift-and-add step.
// Width includes the carry bit that shifts into the product MSB.
module adder #(
  parameter int DATA_WIDTH = 65
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/mul_seq_ctrl.sv
// Sequential shift-and-add multiplier for MUL/MULH/MULHSU/MULHU.
// Magnitudes are multiplied unsigned; sign is restored in one FIX step.
module mul_seq_ctrl
  import mul_pkg::*;
#(
  parameter int DATA_WIDTH = XLEN
) (
  input  logic                  i_clk,
  input  logic                  i_arst,
  input  logic                  i_start,
  input  logic [1:0]            i_op,
  input  logic [DATA_WIDTH-1:0] i_rs1,
  input  logic [DATA_WIDTH-1:0] i_rs2,
  input  logic                  i_kill,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [DATA_WIDTH-1:0] o_result
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = cnt_w(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  mul_state_t state, state_nxt;
  mul_op_t    op_in, op;

  logic [CW-1:0]  count;
  logic [W-1:0]   mcand;
  logic [W-1:0]   hi;
  logic [W-1:0]   lo;
  logic           neg;
  logic [W-1:0]   result;

  logic           accept;
  logic           rs1_neg;
  logic           rs2_neg;
  logic [W-1:0]   abs1;
  logic [W-1:0]   abs2;
  logic [W:0]     add_a;
  logic [W:0]     add_b;
  logic [W:0]     sum;
  logic [2*W-1:0] prod;
  logic [2*W-1:0] fixed;

  assign op_in   = mul_op_t'(i_op);
  assign accept  = (state == S_IDLE) && i_start && !i_kill;
  assign rs1_neg = ((op_in == OP_MULH) || (op_in == OP_MULHSU))
                   && i_rs1[W-1];
  assign rs2_neg = (op_in == OP_MULH) && i_rs2[W-1];
  assign abs1    = rs1_neg ? (~i_rs1 + W'(1)) : i_rs1;
  assign abs2    = rs2_neg ? (~i_rs2 + W'(1)) : i_rs2;

  assign add_a = {1'b0, hi};
  assign add_b = lo[0] ? {1'b0, mcand} : '0;

  adder #(.DATA_WIDTH(W + 1)) u_adder (
    .a   (add_a),
    .b   (add_b),
    .sum (sum)
  );

  assign prod  = {hi, lo};
  assign fixed = neg ? (~prod + (2*W)'(1)) : prod;

  assign o_busy   = (state != S_IDLE);
  assign o_done   = (state == S_DONE) && !i_kill;
  assign o_result = result;

  // State register.
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; a flush always wins.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (accept) state_nxt = S_MUL;
      S_MUL:  if (count == LAST) state_nxt = S_FIX;
      S_FIX:  state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
    endcase
    if (i_kill) state_nxt = S_IDLE;
  end

  // Operand capture, iteration, sign fix and result latch.
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      count  <= '0;
      mcand  <= '0;
      hi     <= '0;
      lo     <= '0;
      neg    <= 1'b0;
      op     <= OP_MUL;
      result <= '0;
    end else if (accept) begin
      count <= '0;
      mcand <= abs1;
      hi    <= '0;
      lo    <= abs2;
      neg   <= rs1_neg ^ rs2_neg;
      op    <= op_in;
    end else if (!i_kill) begin
      if (state == S_MUL) begin
        hi    <= sum[W:1];
        lo    <= {sum[0], lo[W-1:1]};
        count <= count + CW'(1);
      end else if (state == S_FIX) begin
        {hi, lo} <= fixed;
        result   <= (op == OP_MUL) ? fixed[W-1:0]
                                   : fixed[2*W-1:W];
      end
    end
  end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed bench for mul_seq_ctrl with hand-computed products.
// Inputs change and outputs are sampled on the falling edge.
module tb_mul_seq_ctrl;

  localparam logic [1:0] MUL    = 2'b00;
  localparam logic [1:0] MULH   = 2'b01;
  localparam logic [1:0] MULHSU = 2'b10;
  localparam logic [1:0] MULHU  = 2'b11;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [63:0] rs1 = '0;
  logic [63:0] rs2 = '0;
  logic        kill = 1'b0;
  logic        busy;
  logic        done;
  logic [63:0] result;

  int checks = 0;
  int errors = 0;

  mul_seq_ctrl #(.DATA_WIDTH(64)) dut (
    .i_clk    (clk),
    .i_arst   (rst),
    .i_start  (start),
    .i_op     (op),
    .i_rs1    (rs1),
    .i_rs2    (rs2),
    .i_kill   (kill),
    .o_busy   (busy),
    .o_done   (done),
    .o_result (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Caller sits on a falling edge; the start cycle is cycle 0.
  // Done must show in cycle 66, last one cycle, and the next
  // op may start in the very next cycle.
  task automatic run(input string tag,
                     input logic [1:0] o,
                     input logic [63:0] a,
                     input logic [63:0] b,
                     input logic [63:0] exp,
                     input int ign_at);
    int cyc;
    int seen;
    start = 1'b1;
    op    = o;
    rs1   = a;
    rs2   = b;
    seen  = 0;
    for (cyc = 1; cyc <= 200; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      rs1   = 64'hdead_beef_0bad_f00d;
      rs2   = 64'h1234_5678_9abc_def0;
      op    = MULHU;
      if (cyc == ign_at) begin
        start = 1'b1;
        op    = MUL;
      end
      if (done) begin
        seen = cyc;
        break;
      end
    end
    start = 1'b0;
    check({tag, "_latency"}, 64'(seen), 64'd66);
    check({tag, "_result"}, result, exp);
    @(negedge clk);
    check({tag, "_pulse"}, {62'd0, busy, done}, 64'd0);
  endtask

  initial begin
    int k;
    int hits;
    logic [63:0] last;

    #2 rst = 1'b1;
    @(negedge clk);
    check("rst_outputs", {busy, done, 62'd0}, 64'd0);
    check("rst_result", result, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run("mul_3x5", MUL, 64'd3, 64'd5, 64'd15, 0);
    run("mulh_m1m1", MULH, '1, '1, 64'd0, 0);
    run("mul_m1m1", MUL, '1, '1, 64'd1, 0);
    run("mulhu_max", MULHU, '1, '1,
        64'hffff_ffff_ffff_fffe, 0);
    run("mulhsu_m1", MULHSU, '1, '1,
        64'hffff_ffff_ffff_ffff, 0);
    run("mulh_minsq", MULH, 64'h8000_0000_0000_0000,
        64'h8000_0000_0000_0000,
        64'h4000_0000_0000_0000, 0);
    run("mulh_m3x5", MULH, -64'sd3, 64'd5,
        64'hffff_ffff_ffff_ffff, 0);
    run("mul_7xm2", MUL, 64'd7, -64'sd2,
        64'hffff_ffff_ffff_fff2, 0);
    run("mulhsu_pos", MULHSU, 64'd2,
        64'h8000_0000_0000_0000, 64'd1, 0);
    run("ign_start", MUL, 64'd11, 64'd13, 64'd143, 10);

    last = 64'd143;
    start = 1'b1;
    op    = MUL;
    rs1   = 64'd6;
    rs2   = 64'd7;
    for (k = 1; k < 30; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("kill_busy_before", {63'd0, busy}, 64'd1);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    check("kill_busy_after", {63'd0, busy}, 64'd0);
    hits = 0;
    for (k = 0; k < 80; k++) begin
      @(negedge clk);
      if (done) hits++;
    end
    check("kill_no_done", 64'(hits), 64'd0);
    check("kill_result_held", result, last);

    run("after_kill", MULHU, 64'h0000_0001_0000_0000,
        64'h0000_0003_0000_0000, 64'd3, 0);

    start = 1'b1;
    op    = MUL;
    rs1   = 64'd9;
    rs2   = 64'd9;
    for (k = 1; k < 20; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    #1 rst = 1'b1;
    #1;
    check("arst_flags", {62'd0, busy, done}, 64'd0);
    check("arst_result", result, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    hits = 0;
    for (k = 0; k < 80; k++) begin
      @(negedge clk);
      if (done) hits++;
    end
    check("arst_no_done", 64'(hits), 64'd0);

    run("after_rst", MUL, 64'd1000, 64'd1000,
        64'd1000000, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
